mux_lut_unit: RTL and testbench
===============================

# mux_lut_unit

Parametrised, pipelined successor to the single-bit mux-built AND gate. It applies a runtime-programmable 2-input Boolean function, defined by a 4-entry truth table, bitwise across WIDTH-bit operands A and B. Each bit is a 4:1 mux selected by {A[i],B[i]}. The datapath has STAGES register stages with valid/ready flow control, and sits between operand producers and downstream consumers in the logic datapath.

## Interface
- WIDTH, 8, operand and result width in bits (1..64)
- STAGES, 2, pipeline register stages, equal to latency in cycles (1..4)
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- cfg_we  input  1  truth-table write strobe
- cfg_tt  input  4  new truth table; bit index = {A[i],B[i]}
- in_valid  input  1  operands valid
- in_ready  output  1  unit accepts operands this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out  output  WIDTH  result
- tt  output  4  currently active truth table
- out_count  output  16  accepted-result counter (see Configuration)

## Operation
- Reset values:
  - tt = 4'b1000 (AND)
  - all stage-valid flags = 0
  - out_valid = 0
  - out = 0
  - out_count = 0
  - in_ready = 1
- Function: out[i] = tt_issue[{A[i],B[i]}], where tt_issue is the table active in the cycle the operands were accepted.
  - Example encodings: AND = 4'b1000, OR = 4'b1110, XOR = 4'b0110, NAND = 4'b0111.
- Evaluation happens in stage 0, using the registered tt. Results then shift through STAGES-1 further registers.
- Config write: when cfg_we=1, tt takes cfg_tt at that edge. Operands accepted in the same cycle use the old tt.
- In-flight data is never recomputed, so a table change affects only operands accepted afterwards.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Pipeline is a global-stall shift register:
  - advance = !out_valid || out_ready
  - in_ready = advance
  - On advance, every stage takes the stage before it. Stage 0 takes the new operand result and valid = input transfer.
- Occupancy (number of set stage-valid flags) ranges 0..STAGES and is derived, not stored. Bubbles are allowed; they are not compressed.
- out and out_valid come straight from the last stage register (no combinational path from A/B to out).
- Producer must hold A, B and in_valid stable until transfer. The consumer sees out and out_valid held stable while out_ready=0.

## Timing
- Latency: operands transferred at edge N give out_valid=1 with the result after edge N+STAGES-1. The result is visible in cycle N+STAGES-1, assuming no stall.
- Throughput: 1 result/cycle while out_ready=1.
- Stall: out_valid=1 && out_ready=0 freezes all stages and drops in_ready to 0 in the same cycle (combinational from out_ready).
- Result holds with out_valid=1 until its transfer.
- Empty pipeline with out_ready=0: in_ready=1 and data still advances (advance is true because out_valid=0).
- Reset mid-operation: all in-flight results are discarded, out_valid=0 the next cycle, tt returns to AND. A cfg_we in the reset cycle is ignored.
- cfg_we combined with a stall: tt updates; stalled data is unaffected.

## Configuration
- MUX_LUT_COUNT_EN defined:
  - out_count increments by 1 on every output transfer.
  - Saturates at 16'hFFFF.
  - Cleared by rst.
- Not defined: out_count is tied to 16'h0000 and no counter logic is synthesised. All other behaviour is identical.

## Test plan
- Default AND, WIDTH=8, STAGES=2, out_ready=1: A=8'hF0, B=8'hCC -> out=8'hC0, out_valid high exactly 2 cycles after acceptance; tt=4'b1000.
- Reprogram XOR then NAND: cfg_tt=4'b0110 with A=8'hF0, B=8'hCC -> 8'h3C. Then cfg_tt=4'b0111 with A=8'hFF, B=8'h0F -> 8'hF0.
- Table change mid-flight: accept A=8'hAA, B=8'h55 under AND, then write XOR in the next cycle -> first result 8'h00. An operand accepted after the write gives XOR output (8'hAA^8'h55 = 8'hFF).
- Backpressure: stream 4 operands with out_ready=0 for 3 cycles once out_valid is high -> in_ready=0 during the stall, out held constant, all 4 results delivered in order, no loss or duplication.
- Reset mid-operation: assert rst with 2 results in flight -> out_valid=0, out=0, tt=4'b1000 next cycle, no stale result emitted afterwards.
- With MUX_LUT_COUNT_EN: 5 output transfers -> out_count=5. Without the macro, out_count stays 0.

Source files
------------

// File: rtl/mux_lut_unit.sv
// -----------------------------------------------------------------------------
// mux_lut_unit
//
// Purpose:
//   Applies a runtime-programmable 2-input Boolean function bitwise across two
//   WIDTH-bit operands. The function is a 4-entry truth table. Each result bit
//   is a 4:1 mux that picks tt[{A[i],B[i]}]. The result then travels through a
//   STAGES-deep pipeline with valid/ready flow control and a global stall.
//
// Parameters:
//   WIDTH   operand and result width in bits (1..64)
//   STAGES  number of pipeline registers, equal to the latency in cycles (1..4)
//
// Optional feature (compile-time macro):
//   MUX_LUT_COUNT_EN  when defined, out_count counts output transfers and
//                     saturates at 16'hFFFF. When undefined, out_count is tied
//                     to zero and no counter logic exists.
//
// Ports:
//   clk        in   clock; all logic on the rising edge
//   rst        in   synchronous, active-high reset
//   cfg_we     in   truth-table write strobe
//   cfg_tt     in   [3:0] new truth table, bit index = {A[i],B[i]}
//   in_valid   in   operands valid
//   in_ready   out  unit accepts operands this cycle
//   A, B       in   [WIDTH-1:0] operands
//   out_valid  out  result valid (driven by the last stage register)
//   out_ready  in   consumer accepts result
//   out        out  [WIDTH-1:0] result (driven by the last stage register)
//   tt         out  [3:0] currently active truth table
//   out_count  out  [15:0] accepted-result counter
// -----------------------------------------------------------------------------
module mux_lut_unit #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [3:0]       cfg_tt,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [3:0]       tt,
   output logic [15:0]      out_count
);

   localparam logic [3:0] TT_AND = 4'b1000;

   logic [3:0]       tt_reg;
   logic [WIDTH-1:0] eval_bits;
   logic [WIDTH-1:0] data_reg  [STAGES];
   logic             valid_reg [STAGES];
   logic             advance;
   logic             in_xfer;

   // Global stall: every stage moves together, unless the final stage holds a
   // result the consumer is refusing. An empty last stage never blocks, so
   // bubbles flow out even while out_ready is low. Occupancy is simply the
   // number of set valid_reg flags; nothing tracks it separately.
   assign advance  = !valid_reg[STAGES-1] || out_ready;
   assign in_ready = advance;
   assign in_xfer  = in_valid && advance;

   // Truth-table register. Operands accepted in the same cycle as a write
   // still see the old table, because evaluation reads tt_reg, not cfg_tt.
   always_ff @(posedge clk) begin
      if (rst) begin
         tt_reg <= TT_AND;
      end else if (cfg_we) begin
         tt_reg <= cfg_tt;
      end
   end

   assign tt = tt_reg;

   // One 4:1 mux per bit, with the operand bit pair acting as the select.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit_mux
         assign eval_bits[gi] = tt_reg[{A[gi], B[gi]}];
      end
   endgenerate

   // Stage 0 captures the evaluated result. Later stages only shift, so data
   // already in flight is never recomputed after a table change.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < STAGES; s++) begin
            valid_reg[s] <= 1'b0;
            data_reg[s]  <= '0;
         end
      end else if (advance) begin
         valid_reg[0] <= in_xfer;
         data_reg[0]  <= eval_bits;
         for (int s = 1; s < STAGES; s++) begin
            valid_reg[s] <= valid_reg[s-1];
            data_reg[s]  <= data_reg[s-1];
         end
      end
   end

   assign out_valid = valid_reg[STAGES-1];
   assign out       = data_reg[STAGES-1];

`ifdef MUX_LUT_COUNT_EN
   logic        out_xfer;
   logic [15:0] count_reg;

   assign out_xfer = valid_reg[STAGES-1] && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= 16'h0000;
      end else if (out_xfer && (count_reg != 16'hFFFF)) begin
         count_reg <= count_reg + 16'd1;
      end
   end

   assign out_count = count_reg;
`else
   assign out_count = 16'h0000;
`endif

endmodule

// File: tb/tb_mux_lut_unit.sv
// -----------------------------------------------------------------------------
// tb_mux_lut_unit
//
// Self-checking bench for mux_lut_unit (WIDTH=8, STAGES=2). A scoreboard
// queue receives the model result at every input transfer and is popped and
// compared at every output transfer. A vector table drives the function
// checks, and hand-written sequences cover latency, same-cycle table writes,
// backpressure, an empty-pipe stall, reset mid-flight and the result counter.
// -----------------------------------------------------------------------------
module tb_mux_lut_unit;

   localparam int W      = 8;
   localparam int STAGES = 2;
`ifdef MUX_LUT_COUNT_EN
   localparam logic [15:0] EXP_CNT5 = 16'd5;
`else
   localparam logic [15:0] EXP_CNT5 = 16'd0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_we;
   logic [3:0]    cfg_tt;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out;
   logic [3:0]    tt;
   logic [15:0]   out_count;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [W-1:0]  sb[$];
   logic [3:0]    tt_model = 4'b1000;
   logic [15:0]   cnt_model = 16'h0000;
   logic [W-1:0]  held;

   typedef struct {
      logic [3:0]   tt;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
   } vec_t;

   vec_t vecs[8];

   mux_lut_unit #(.WIDTH(W), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_tt    (cfg_tt),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .tt        (tt),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] lut_eval(input logic [3:0] t,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) begin
         r[i] = t[{a[i], b[i]}];
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic fail_timeout(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: timed out, required event never came", name);
   endtask

   // Present operands and hold them until the unit takes them. Returns just
   // after the transfer edge with in_valid still asserted.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
      bit ok = 1'b0;
      A = a;
      B = b;
      in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) fail_timeout("send");
      @(posedge clk);
      #1;
   endtask

   // Reference table register.
   always @(posedge clk) begin
      if (rst) tt_model <= 4'b1000;
      else if (cfg_we) tt_model <= cfg_tt;
   end

   // Scoreboard: transfers are decided by signals stable at the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         cnt_model = 16'h0000;
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL sb_extra: got result %0h, required none pending", out);
            end else begin
               check("sb_data", out, sb.pop_front());
            end
            check("out_count", out_count, cnt_model);
`ifdef MUX_LUT_COUNT_EN
            if (cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
`endif
         end
         if (in_valid && in_ready) sb.push_back(lut_eval(tt_model, A, B));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, required finish before 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{tt: 4'b1000, a: 8'hF0, b: 8'hCC, exp: 8'hC0};  // AND
      vecs[1] = '{tt: 4'b0110, a: 8'hF0, b: 8'hCC, exp: 8'h3C};  // XOR
      vecs[2] = '{tt: 4'b0111, a: 8'hFF, b: 8'h0F, exp: 8'hF0};  // NAND
      vecs[3] = '{tt: 4'b1110, a: 8'hA0, b: 8'h05, exp: 8'hA5};  // OR
      vecs[4] = '{tt: 4'b0000, a: 8'hFF, b: 8'hFF, exp: 8'h00};  // const 0
      vecs[5] = '{tt: 4'b1111, a: 8'h00, b: 8'h00, exp: 8'hFF};  // const 1
      vecs[6] = '{tt: 4'b0010, a: 8'hF0, b: 8'hCC, exp: 8'h0C};  // ~A & B
      vecs[7] = '{tt: 4'b0100, a: 8'hF0, b: 8'hCC, exp: 8'h30};  // A & ~B

      rst = 1'b1; cfg_we = 1'b0; cfg_tt = 4'h0; in_valid = 1'b0;
      A = '0; B = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_tt", tt, 4'b1000);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out", out, 8'h00);
      check("rst_out_count", out_count, 16'h0000);
      check("rst_in_ready", in_ready, 1'b1);

      // Latency: result appears exactly STAGES-1 edges after the transfer edge
      @(posedge clk); #1;
      send(8'hF0, 8'hCC);
      in_valid = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         check("lat_valid", out_valid, (k == STAGES - 1));
         if (k == STAGES - 1) check("lat_data", out, 8'hC0);
         @(posedge clk); #1;
      end
      check("lat_pulse_end", out_valid, 1'b0);
      check("lat_tt", tt, 4'b1000);

      // Table-driven function checks
      for (int v = 0; v < 8; v++) begin
         cfg_we = 1'b1;
         cfg_tt = vecs[v].tt;
         @(posedge clk); #1;
         cfg_we = 1'b0;
         check("vec_tt", tt, vecs[v].tt);
         send(vecs[v].a, vecs[v].b);
         in_valid = 1'b0;
         repeat (STAGES - 1) begin
            @(posedge clk); #1;
         end
         check("vec_valid", out_valid, 1'b1);
         check("vec_out", out, vecs[v].exp);
         @(posedge clk); #1;
      end

      // Table change while data is in flight, and in the acceptance cycle
      cfg_we = 1'b1; cfg_tt = 4'b1000;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      send(8'hAA, 8'h55);                 // AND -> 00
      cfg_we = 1'b1; cfg_tt = 4'b0110;
      send(8'h0F, 8'hFF);                 // same cycle as write, still AND -> 0F
      cfg_we = 1'b0;
      check("mid_first", out, 8'h00);
      check("mid_first_v", out_valid, 1'b1);
      send(8'hAA, 8'h55);                 // XOR -> FF
      in_valid = 1'b0;
      check("mid_same_cycle", out, 8'h0F);
      @(posedge clk); #1;
      check("mid_after", out, 8'hFF);
      check("mid_tt", tt, 4'b0110);
      repeat (3) @(posedge clk);
      #1;

      // Backpressure: 3-cycle stall with a full pipe, table write during stall
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               send(W'($urandom), W'($urandom));
            end
            in_valid = 1'b0;
         end
         begin
            bit seen = 1'b0;
            for (int c = 0; c < 50; c++) begin
               @(posedge clk); #1;
               if (out_valid) begin
                  seen = 1'b1;
                  break;
               end
            end
            if (!seen) fail_timeout("bp_first_valid");
            out_ready = 1'b0;
            held = out;
            cfg_we = 1'b1;
            cfg_tt = 4'b1110;
            for (int s = 0; s < 3; s++) begin
               @(negedge clk);
               check("bp_in_ready", in_ready, 1'b0);
               check("bp_out_held", out, held);
               check("bp_valid_held", out_valid, 1'b1);
               @(posedge clk); #1;
               cfg_we = 1'b0;
            end
            out_ready = 1'b1;
         end
      join
      repeat (8) @(posedge clk);
      #1;
      check("bp_tt", tt, 4'b1110);
      check("bp_drained", sb.size(), 0);

      // Empty pipe with consumer not ready still accepts and advances
      out_ready = 1'b0;
      @(negedge clk);
      check("empty_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      send(8'h5A, 8'hA5);
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("empty_valid", out_valid, 1'b1);
      check("empty_out", out, lut_eval(4'b1110, 8'h5A, 8'hA5));
      @(negedge clk);
      check("empty_stall_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      check("empty_stall_valid", out_valid, 1'b1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("empty_released", out_valid, 1'b0);

      // Reset with two results in flight; cfg write in the reset cycle ignored
      send(8'h11, 8'h22);
      send(8'h33, 8'h44);
      in_valid = 1'b0;
      rst = 1'b1;
      cfg_we = 1'b1;
      cfg_tt = 4'b0110;
      @(posedge clk); #1;
      rst = 1'b0;
      cfg_we = 1'b0;
      check("mrst_valid", out_valid, 1'b0);
      check("mrst_out", out, 8'h00);
      check("mrst_tt", tt, 4'b1000);
      check("mrst_in_ready", in_ready, 1'b1);
      check("mrst_count", out_count, 16'h0000);
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         check("mrst_no_stale", out_valid, 1'b0);
      end

      // Counter: five output transfers after reset
      for (int i = 0; i < 5; i++) begin
         send(W'($urandom), W'($urandom));
      end
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("count5", out_count, EXP_CNT5);
      check("final_drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
